// File: rtl/onp_stream_converter.sv
// Streaming infix -> RPN (shunting-yard) converter with an internal operator stack.
// Consumes one infix token per handshake and emits RPN tokens through a single output register.
module onp_stream_converter #(
  parameter int DW    = 32,
  parameter int DEPTH = 16
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic [DW-1:0]            I_DAT,
  input  logic                     I_OP,
  input  logic                     I_STB,
  output logic                     I_ACK,
  output logic [DW-1:0]            O_DAT,
  output logic                     O_OP,
  output logic                     O_STB,
  input  logic                     O_ACK,
  output logic                     O_ERR,
  output logic [$clog2(DEPTH):0]   O_DEPTH
);
  localparam int AW = $clog2(DEPTH);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_POPOP  = 3'd1;
  localparam logic [2:0] S_POPPAR = 3'd2;
  localparam logic [2:0] S_FLUSH  = 3'd3;
  localparam logic [2:0] S_ERR    = 3'd4;

  localparam logic [7:0] C_ADD = 8'h2B;
  localparam logic [7:0] C_SUB = 8'h2D;
  localparam logic [7:0] C_MUL = 8'h2A;
  localparam logic [7:0] C_DIV = 8'h2F;
  localparam logic [7:0] C_LP  = 8'h28;
  localparam logic [7:0] C_RP  = 8'h29;
  localparam logic [7:0] C_EQ  = 8'h3D;

  logic [2:0]    state, nstate;
  logic [AW:0]   sp, sp_m1;
  logic [7:0]    stk [DEPTH];
  logic [7:0]    lat, top, code, push_code;
  logic [DW-1:0] o_dat, ld_dat;
  logic          o_stb, o_op, run;
  logic          slot_free, empty, full, top_par, xfer;
  logic          push, pop, ld, ld_op, lat_ld, clr;

  function automatic logic [1:0] prec(input logic [7:0] c);
    prec = (c == C_MUL || c == C_DIV) ? 2'd2 :
           (c == C_ADD || c == C_SUB) ? 2'd1 : 2'd0;
  endfunction

  function automatic logic [DW-1:0] opw(input logic [7:0] c);
    opw      = '0;
    opw[7:0] = c;
  endfunction

  assign slot_free = !o_stb || O_ACK;
  assign empty     = (sp == '0);
  assign full      = (sp == (AW+1)'(DEPTH));
  assign sp_m1     = sp - 1'b1;
  assign top       = stk[sp_m1[AW-1:0]];
  assign top_par   = (top == C_LP);
  assign code      = I_DAT[7:0];
  // I_ACK stays low until the first clock after reset release
  assign I_ACK     = run && ((state == S_IDLE && slot_free) || state == S_ERR);
  assign xfer      = I_STB && I_ACK;

  assign O_DAT   = o_dat;
  assign O_OP    = o_op;
  assign O_STB   = o_stb;
  assign O_ERR   = (state == S_ERR);
  assign O_DEPTH = sp;

  always_comb begin
    nstate    = state;
    push      = 1'b0;
    pop       = 1'b0;
    push_code = lat;
    ld        = 1'b0;
    ld_dat    = '0;
    ld_op     = 1'b0;
    lat_ld    = 1'b0;
    clr       = 1'b0;
    case (state)
      S_IDLE: if (xfer) begin
        if (!I_OP) begin
          ld     = 1'b1;
          ld_dat = I_DAT;
        end else begin
          case (code)
            C_LP: if (full) nstate = S_ERR;
                  else begin push = 1'b1; push_code = C_LP; end
            C_ADD, C_SUB, C_MUL, C_DIV: begin lat_ld = 1'b1; nstate = S_POPOP; end
            C_RP:    nstate = S_POPPAR;
            C_EQ:    nstate = S_FLUSH;
            default: nstate = S_ERR;
          endcase
        end
      end
      // a poppable operator waiting on a busy output slot stalls rather than being pushed over
      S_POPOP: begin
        if (!empty && !top_par && prec(top) >= prec(lat)) begin
          if (slot_free) begin pop = 1'b1; ld = 1'b1; ld_dat = opw(top); ld_op = 1'b1; end
        end else if (!full) begin
          push   = 1'b1;
          nstate = S_IDLE;
        end else nstate = S_ERR;
      end
      S_POPPAR: begin
        if (empty) nstate = S_ERR;
        else if (top_par) begin pop = 1'b1; nstate = S_IDLE; end
        else if (slot_free) begin pop = 1'b1; ld = 1'b1; ld_dat = opw(top); ld_op = 1'b1; end
      end
      S_FLUSH: begin
        if (empty) begin
          if (slot_free) begin ld = 1'b1; ld_dat = opw(C_EQ); ld_op = 1'b1; nstate = S_IDLE; end
        end else if (top_par) nstate = S_ERR;
        else if (slot_free) begin pop = 1'b1; ld = 1'b1; ld_dat = opw(top); ld_op = 1'b1; end
      end
      default: if (xfer && I_OP && code == C_EQ) begin
        clr    = 1'b1;
        nstate = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= S_IDLE;
      sp    <= '0;
      lat   <= '0;
      o_stb <= 1'b0;
      o_dat <= '0;
      o_op  <= 1'b0;
      run   <= 1'b0;
    end else begin
      state <= nstate;
      run   <= 1'b1;
      if (lat_ld) lat <= code;
      if (clr) sp <= '0;
      else if (push) sp <= sp + 1'b1;
      else if (pop) sp <= sp_m1;
      if (ld) begin
        o_stb <= 1'b1;
        o_dat <= ld_dat;
        o_op  <= ld_op;
      end else if (O_ACK) o_stb <= 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) stk[sp[AW-1:0]] <= push_code;
  end
endmodule

// File: tb/tb_onp_stream_converter.sv
// Bench for onp_stream_converter: constant vector table, hand sequences and a random
// stream checked against a queue-based shunting-yard reference.
module tb_onp_stream_converter;
  localparam int DW = 32;
  localparam int DEPTH = 4;
  localparam int DPW = $clog2(DEPTH) + 1;

  logic           CLK = 1'b0;
  logic           RST_N = 1'b0;
  logic [DW-1:0]  I_DAT = '0;
  logic           I_OP = 1'b0;
  logic           I_STB = 1'b0;
  logic           I_ACK;
  logic [DW-1:0]  O_DAT;
  logic           O_OP;
  logic           O_STB;
  logic           O_ACK = 1'b0;
  logic           O_ERR;
  logic [DPW-1:0] O_DEPTH;

  onp_stream_converter #(.DW(DW), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST_N(RST_N), .I_DAT(I_DAT), .I_OP(I_OP), .I_STB(I_STB), .I_ACK(I_ACK),
    .O_DAT(O_DAT), .O_OP(O_OP), .O_STB(O_STB), .O_ACK(O_ACK), .O_ERR(O_ERR), .O_DEPTH(O_DEPTH)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad = 0;
  int ack_mode = 0;
  int scnt = 0;
  logic [32:0] got[$];
  logic [32:0] exp_q[$];
  logic        hold = 1'b0;
  logic [32:0] held;

  typedef struct {
    string in;
    string exp;
    logic  err;
    int    dep;
  } vec_t;
  vec_t vt[10];

  // reference model state
  logic [7:0] m_stk[$];
  logic       m_err = 1'b0;

  always @(posedge CLK) begin
    #1;
    case (ack_mode)
      0: O_ACK = 1'b1;
      1: O_ACK = 1'($urandom_range(0, 1));
      default: if (O_STB && scnt < 5) begin O_ACK = 1'b0; scnt++; end
               else begin O_ACK = 1'b1; scnt = 0; end
    endcase
  end

  always @(negedge CLK) begin
    if (RST_N) begin
      if (hold && O_STB) begin
        total++;
        if ({O_OP, O_DAT} !== held) begin
          bad++;
          $display("FAIL hold_stable got=%h exp=%h", {O_OP, O_DAT}, held);
        end
      end
      if (O_STB && O_ACK) got.push_back({O_OP, O_DAT});
      hold = O_STB && !O_ACK;
      held = {O_OP, O_DAT};
    end else hold = 1'b0;
  end

  function automatic logic [32:0] ctok(input byte c);
    if (c >= "0" && c <= "9") return {1'b0, 32'(c - "0")};
    return {1'b1, 24'd0, c};
  endfunction

  function automatic logic [1:0] mprec(input logic [7:0] c);
    if (c == "*" || c == "/") return 2'd2;
    if (c == "+" || c == "-") return 2'd1;
    return 2'd0;
  endfunction

  task automatic chk(input string nm, input logic [32:0] act, input logic [32:0] e);
    total++;
    if (act !== e) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, act, e);
    end
  endtask

  task automatic send(input logic [32:0] t);
    int n = 0;
    I_OP = t[32]; I_DAT = t[31:0]; I_STB = 1'b1;
    do begin @(negedge CLK); n++; end while (!I_ACK && n < 300);
    if (!I_ACK) begin
      total++; bad++;
      $display("FAIL send_timeout got=I_ACK low exp=accept tok=%h", t);
    end
    @(posedge CLK); #1;
    I_STB = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(ctok(s[i]));
  endtask

  task automatic exp_str(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(ctok(s[i]));
  endtask

  task automatic check_out(input string nm, input logic e_err, input int e_dep);
    int n = 0;
    int m;
    while (got.size() < exp_q.size() && n < 3000) begin @(negedge CLK); n++; end
    repeat (15) @(negedge CLK);
    chk({nm, "_count"}, 33'(got.size()), 33'(exp_q.size()));
    m = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < m; i++) chk($sformatf("%s_tok%0d", nm, i), got[i], exp_q[i]);
    chk({nm, "_err"}, 33'(O_ERR), 33'(e_err));
    chk({nm, "_depth"}, 33'(O_DEPTH), 33'(e_dep));
    got.delete();
    exp_q.delete();
    @(posedge CLK); #1;
  endtask

  // shunting-yard over a queue stack, applied token by token
  task automatic model(input logic [32:0] t);
    logic [7:0] c = t[7:0];
    if (m_err) begin
      if (t[32] && c == "=") begin m_err = 1'b0; m_stk.delete(); end
    end else if (!t[32]) exp_q.push_back(t);
    else if (c == "(") begin
      if (m_stk.size() == DEPTH) m_err = 1'b1; else m_stk.push_back(c);
    end else if (c == "+" || c == "-" || c == "*" || c == "/") begin
      while (m_stk.size() > 0 && m_stk[$] != "(" && mprec(m_stk[$]) >= mprec(c))
        exp_q.push_back({1'b1, 24'd0, m_stk.pop_back()});
      if (m_stk.size() == DEPTH) m_err = 1'b1; else m_stk.push_back(c);
    end else if (c == ")") begin
      forever begin
        if (m_stk.size() == 0) begin m_err = 1'b1; break; end
        if (m_stk[$] == "(") begin void'(m_stk.pop_back()); break; end
        exp_q.push_back({1'b1, 24'd0, m_stk.pop_back()});
      end
    end else if (c == "=") begin
      forever begin
        if (m_stk.size() == 0) begin exp_q.push_back({1'b1, 24'd0, 8'h3D}); break; end
        if (m_stk[$] == "(") begin m_err = 1'b1; break; end
        exp_q.push_back({1'b1, 24'd0, m_stk.pop_back()});
      end
    end else m_err = 1'b1;
  endtask

  initial begin
    logic [32:0] t;
    string ops;
    string bads;
    vt[0] = '{"3+4*2=",     "342*+=",     1'b0, 0};
    vt[1] = '{"(1+2)*3=",   "12+3*=",     1'b0, 0};
    vt[2] = '{"8-3-2=",     "83-2-=",     1'b0, 0};
    vt[3] = '{"1-2*3/4+5=", "123*4/-5+=", 1'b0, 0};
    vt[4] = '{"1)=",        "1",          1'b0, 0};
    vt[5] = '{"(2=",        "2",          1'b1, 1};
    vt[6] = '{"=5=",        "5=",         1'b0, 0};
    vt[7] = '{"1x2=",       "1",          1'b0, 0};
    vt[8] = '{"((((1))))=", "1=",         1'b0, 0};
    vt[9] = '{"2*(3+4)=",   "234+*=",     1'b0, 0};
    ops  = "+-*/";
    bads = "x";

    #2;
    chk("rst_ostb", 33'(O_STB), 33'd0);
    chk("rst_odat", 33'(O_DAT), 33'd0);
    chk("rst_oop", 33'(O_OP), 33'd0);
    chk("rst_oerr", 33'(O_ERR), 33'd0);
    chk("rst_depth", 33'(O_DEPTH), 33'd0);
    chk("rst_iack", 33'(I_ACK), 33'd0);
    #20 RST_N = 1'b1;
    @(posedge CLK); #1;
    @(posedge CLK); #1;

    foreach (vt[k]) begin
      send_str(vt[k].in);
      exp_str(vt[k].exp);
      check_out($sformatf("vec%0d", k), vt[k].err, vt[k].dep);
    end

    // stack overflow at the fifth "(" with DEPTH=4
    send_str("((((");
    chk("ovf_depth4", 33'(O_DEPTH), 33'd4);
    chk("ovf_noerr", 33'(O_ERR), 33'd0);
    send_str("(");
    chk("ovf_err", 33'(O_ERR), 33'd1);
    send_str("1+");
    chk("ovf_sticky", 33'(O_ERR), 33'd1);
    send_str("=");
    check_out("ovf_clear", 1'b0, 0);
    send_str("5=");
    exp_str("5=");
    check_out("ovf_after", 1'b0, 0);

    // unbalanced ")" raises the error after the number has gone out
    send_str("1)");
    repeat (3) @(negedge CLK);
    chk("rp_err", 33'(O_ERR), 33'd1);
    @(posedge CLK); #1;
    send_str("=");
    exp_str("1");
    check_out("rp_clear", 1'b0, 0);

    // long downstream stalls
    ack_mode = 2;
    send_str("9/3-1=");
    exp_str("93/1-=");
    check_out("stall", 1'b0, 0);
    ack_mode = 0;

    // reset while flushing
    send_str("1+2*3=");
    #1 RST_N = 1'b0;
    #1;
    chk("midrst_ostb", 33'(O_STB), 33'd0);
    chk("midrst_depth", 33'(O_DEPTH), 33'd0);
    chk("midrst_err", 33'(O_ERR), 33'd0);
    chk("midrst_iack", 33'(I_ACK), 33'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    got.delete();
    exp_q.delete();
    @(posedge CLK); #1;
    send_str("7=");
    exp_str("7=");
    check_out("midrst_after", 1'b0, 0);

    // random token streams against the reference model
    for (int it = 0; it < 30; it++) begin
      int r;
      ack_mode = it % 3;
      m_err = 1'b0;
      m_stk.delete();
      for (int j = 0; j < 32; j++) begin
        r = $urandom_range(0, 99);
        if (j >= 30) t = ctok("=");
        else if (r < 40) t = {1'b0, 32'($urandom)};
        else if (r < 70) t = ctok(ops[$urandom_range(0, 3)]);
        else if (r < 80) t = ctok("(");
        else if (r < 90) t = ctok(")");
        else if (r < 96) t = ctok("=");
        else t = ctok(bads[0]);
        model(t);
        send(t);
      end
      check_out($sformatf("rnd%0d", it), m_err, m_stk.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
